color_scan_ctrl: RTL
====================

# color_scan_ctrl

Sequencer for the light-to-frequency colour sensor on the colour conduit. It steps the sensor's photodiode filter select through red, green and blue and counts the sensor's square-wave output over a fixed gate window per filter. It then presents one RGB triple with a single-cycle `get_it` strobe. It sits between the conduit pins (`in_sq`, `s_ctrl`, `get_it`) and the Avalon-MM slave wrapper that the Nios II polls before forwarding colour data over the UART.

## Interface
- `GATE_CYCLES`, 50000: clock cycles per counting window (1 ms at 50 MHz); ≥1.
- `SETTLE_CYCLES`, 500: cycles waited after a filter change before counting; ≥1.
- `CNT_W`, 16: width of each colour count.

- `clk`  in  1  system clock, single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request for a single RGB frame; sampled only in IDLE.
- `continuous`  in  1  level; when high, a new frame begins immediately after each completed frame.
- `in_sq`  in  1  sensor square-wave output, asynchronous to `clk`.
- `s_ctrl`  out  2  filter select {S2,S3}: 00 red, 11 green, 01 blue, 10 clear.
- `get_it`  out  1  one-cycle strobe: `red`/`green`/`blue` updated this cycle.
- `busy`  out  1  high in any state other than IDLE.
- `red`, `green`, `blue`  out  CNT_W each  latched edge counts of the last completed frame.
- `clear`  out  CNT_W  clear-filter count; present only with `COLOR_CLEAR_EN`.

## Operation
- `in_sq` passes through a 2-flop synchroniser plus an edge register; a rising edge is one-cycle `rise`.
- FSM states: IDLE, SETTLE, GATE, DONE. A channel index `ch` runs R→G→B (→C with macro).
- IDLE: `s_ctrl`=10, `busy`=0. `start`=1 or `continuous`=1 → SETTLE with `ch`=R and the timer loaded.
- SETTLE: `s_ctrl` = code of `ch`; runs SETTLE_CYCLES cycles → GATE; the working counter is cleared on entry to GATE.
- GATE: each `rise` increments the working counter. The counter saturates at 2^CNT_W−1; no wrap.
- GATE end after GATE_CYCLES cycles:
  - The count is stored to the shadow register for `ch`.
  - If `ch` is the last channel → DONE; otherwise `ch` advances → SETTLE.
- DONE (one cycle): all shadow registers copy to the outputs and `get_it`=1. Then:
  - `continuous`=1 → SETTLE with `ch`=R.
  - Otherwise → IDLE.
- `start` outside IDLE is ignored; it is not queued.
- `rise` during SETTLE, IDLE or DONE is discarded. A `rise` on the final GATE cycle is counted.
- Outputs hold their value between frames and change only in DONE.
- Reset (any time, including mid-GATE):
  - `s_ctrl`=10, `get_it`=0, `busy`=0, all counts 0, FSM in IDLE, synchroniser cleared.
  - A partially measured frame is discarded.

## Timing
- `start` sampled high at edge T0 → SETTLE from T0+1.
- `get_it` is high in cycle T0 + N·(SETTLE_CYCLES+GATE_CYCLES) + 1, where N = 3 (4 with macro).
- In continuous mode the `get_it` period is N·(SETTLE_CYCLES+GATE_CYCLES)+1 cycles.
- `in_sq` rising edge to counter increment: 3 cycles of latency. An edge arriving up to 3 cycles before GATE ends may fall in the next window's SETTLE and is lost.
- `in_sq` high and low times must each be ≥2 `clk` periods to be counted reliably.
- `s_ctrl` changes on the clock edge that enters SETTLE; it is registered and glitch-free.

## Configuration
- `COLOR_CLEAR_EN` defined:
  - A fourth channel C (`s_ctrl`=10) is measured after blue.
  - The `clear` port exists and updates in DONE.
  - N = 4.
- `COLOR_CLEAR_EN` not defined:
  - Only R, G, B are measured.
  - The `clear` port and its shadow register are absent.
  - N = 3.

## Test plan
Parameters for all scenarios: GATE_CYCLES=100, SETTLE_CYCLES=10, CNT_W=8, no macro unless stated.
- `in_sq` period 10 cycles, `start` at T0 → `get_it` only at T0+331; `red`=`green`=`blue`=10; `busy` high for T0+1..T0+331.
- Bench drives the `in_sq` period from `s_ctrl`: 00→4, 11→5, 01→10 → `red`=25, `green`=20, `blue`=10.
- CNT_W=4, `in_sq` period 4 → all counts 15 (saturated, not wrapped).
- Second `start` pulses at T0+50 and T0+200 → exactly one `get_it`, at T0+331.
- `continuous`=1 held, `in_sq` period 10:
  - `get_it` at T0+331, T0+662, T0+993, each with counts 10.
  - `continuous` dropped → returns to IDLE after the current DONE.
- `reset_n` low at T0+150 (mid-green GATE):
  - Immediately `s_ctrl`=10, `busy`=0, counts 0.
  - `start` after release → normal frame 331 cycles later.
  - With `COLOR_CLEAR_EN`: the same frame gives `get_it` at T0+441 and `clear`=10.

Source files
------------

// File: rtl/color_scan_ctrl.sv
// Colour sensor sequencer: steps the filter select through R/G/B, counts in_sq edges per gate window
// and presents one RGB frame with a get_it strobe. Define COLOR_CLEAR_EN to also measure the clear filter.
module color_scan_ctrl #(
    parameter int GATE_CYCLES   = 50000,
    parameter int SETTLE_CYCLES = 500,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             in_sq,
    output logic [1:0]       s_ctrl,
    output logic             get_it,
    output logic             busy,
    output logic [CNT_W-1:0] red,
    output logic [CNT_W-1:0] green,
    output logic [CNT_W-1:0] blue
`ifdef COLOR_CLEAR_EN
    ,
    output logic [CNT_W-1:0] clear
`endif
);

`ifdef COLOR_CLEAR_EN
    localparam int NUM_CH = 4;
`else
    localparam int NUM_CH = 3;
`endif
    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

    localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CYC + 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);

    localparam logic [1:0] CODE_RED   = 2'b00;
    localparam logic [1:0] CODE_CLEAR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        GATE   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [TMR_W-1:0]  timer_reg, timer_next;
    logic [1:0]        ch_reg, ch_next;
    logic [1:0]        s_ctrl_reg, s_ctrl_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
    logic              gate_end;
    logic              get_it_reg;
    logic              sync1_reg, sync2_reg, prev_reg;
    logic              rise;

    // Shadow registers hold every channel except the last, which goes straight to the outputs.
    logic [CNT_W-1:0]  shadow_reg [NUM_CH-1];
    logic [CNT_W-1:0]  red_reg, green_reg, blue_reg;
`ifdef COLOR_CLEAR_EN
    logic [CNT_W-1:0]  clear_reg;
`endif

    function automatic logic [1:0] ch_code(input logic [1:0] c);
        case (c)
            2'd0:    ch_code = 2'b00;
            2'd1:    ch_code = 2'b11;
            2'd2:    ch_code = 2'b01;
            default: ch_code = 2'b10;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= in_sq;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign rise    = sync2_reg & ~prev_reg;
    assign cnt_inc = (rise && cnt_reg != {CNT_W{1'b1}}) ? cnt_reg + 1'b1 : cnt_reg;

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        ch_next     = ch_reg;
        s_ctrl_next = s_ctrl_reg;
        cnt_next    = cnt_reg;
        gate_end    = 1'b0;
        case (state_reg)
            IDLE: begin
                s_ctrl_next = CODE_CLEAR;
                if (start || continuous) begin
                    state_next  = SETTLE;
                    ch_next     = 2'd0;
                    timer_next  = SETTLE_LOAD;
                    s_ctrl_next = CODE_RED;
                end
            end
            SETTLE: begin
                if (timer_reg == '0) begin
                    state_next = GATE;
                    timer_next = GATE_LOAD;
                    cnt_next   = '0;
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            GATE: begin
                cnt_next = cnt_inc;
                if (timer_reg == '0) begin
                    gate_end = 1'b1;
                    if (ch_reg == LAST_CH) begin
                        state_next = DONE;
                    end else begin
                        state_next  = SETTLE;
                        ch_next     = ch_reg + 2'd1;
                        timer_next  = SETTLE_LOAD;
                        s_ctrl_next = ch_code(ch_reg + 2'd1);
                    end
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            DONE: begin
                if (continuous) begin
                    state_next  = SETTLE;
                    ch_next     = 2'd0;
                    timer_next  = SETTLE_LOAD;
                    s_ctrl_next = CODE_RED;
                end else begin
                    state_next  = IDLE;
                    s_ctrl_next = CODE_CLEAR;
                end
            end
            default: begin
                state_next  = IDLE;
                s_ctrl_next = CODE_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            timer_reg  <= '0;
            ch_reg     <= 2'd0;
            s_ctrl_reg <= CODE_CLEAR;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            ch_reg     <= ch_next;
            s_ctrl_reg <= s_ctrl_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Outputs load on the edge entering DONE so they are already valid while get_it is high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH - 1; i++) shadow_reg[i] <= '0;
            red_reg    <= '0;
            green_reg  <= '0;
            blue_reg   <= '0;
`ifdef COLOR_CLEAR_EN
            clear_reg  <= '0;
`endif
            get_it_reg <= 1'b0;
        end else begin
            get_it_reg <= gate_end && (ch_reg == LAST_CH);
            if (gate_end) begin
                for (int i = 0; i < NUM_CH - 1; i++)
                    if (ch_reg == 2'(i)) shadow_reg[i] <= cnt_inc;
                if (ch_reg == LAST_CH) begin
                    red_reg   <= shadow_reg[0];
                    green_reg <= shadow_reg[1];
`ifdef COLOR_CLEAR_EN
                    blue_reg  <= shadow_reg[2];
                    clear_reg <= cnt_inc;
`else
                    blue_reg  <= cnt_inc;
`endif
                end
            end
        end
    end

    assign s_ctrl = s_ctrl_reg;
    assign get_it = get_it_reg;
    assign busy   = (state_reg != IDLE);
    assign red    = red_reg;
    assign green  = green_reg;
    assign blue   = blue_reg;
`ifdef COLOR_CLEAR_EN
    assign clear  = clear_reg;
`endif

endmodule
